// File: rtl/spi_slave_fsm.sv
// SPI slave front end for the single-port RAM: deserialises {cmd, payload}
// frames from MOSI and serialises RAM read data back onto MISO.
module spi_slave_fsm #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [ADDR_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int FRAME_W = ADDR_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(ADDR_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_done_q, rd_addr_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 miso_q, miso_d;
  logic [ADDR_W-1:0]    tx_sr_q, tx_sr_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    frame_done_d   = frame_done_q;
    miso_d         = miso_q;
    tx_sr_d        = tx_sr_q;
    tx_cnt_d       = tx_cnt_q;

    if (state_q != IDLE && SS_n) begin
      // Frame abort: rx_data and rd_addr_done deliberately survive.
      state_d      = IDLE;
      cnt_d        = '0;
      shift_d      = '0;
      frame_done_d = 1'b0;
      miso_d       = 1'b0;
      tx_sr_d      = '0;
      tx_cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          shift_d = {shift_q[FRAME_W-2:0], MOSI};
          cnt_d   = CNT_W'(1);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done_q) begin
            if (cnt_q != CNT_FULL) begin
              shift_d = {shift_q[FRAME_W-2:0], MOSI};
              cnt_d   = cnt_q + CNT_W'(1);
            end else begin
              rx_data_d    = shift_q;
              rx_valid_d   = 1'b1;
              frame_done_d = 1'b1;
              case (shift_q[FRAME_W-1 -: 2])
                2'b10:   rd_addr_done_d = 1'b1;
                2'b11:   rd_addr_done_d = 1'b0;
                default: rd_addr_done_d = rd_addr_done_q;
              endcase
            end
          end else if (state_q == READ_DATA) begin
            // tx_cnt_q == 0 means serialisation has not yet been started.
            if (tx_cnt_q == '0) begin
              if (tx_valid) begin
                miso_d   = tx_data[ADDR_W-1];
                tx_sr_d  = tx_data << 1;
                tx_cnt_d = TXC_W'(1);
              end
            end else if (tx_cnt_q != TX_LAST) begin
              miso_d   = tx_sr_q[ADDR_W-1];
              tx_sr_d  = tx_sr_q << 1;
              tx_cnt_d = tx_cnt_q + TXC_W'(1);
            end else begin
              miso_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      frame_done_q   <= 1'b0;
      miso_q         <= 1'b0;
      tx_sr_q        <= '0;
      tx_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      frame_done_q   <= frame_done_d;
      miso_q         <= miso_d;
      tx_sr_q        <= tx_sr_d;
      tx_cnt_q       <= tx_cnt_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: frame-level model keyed on edges since SS_n fell,
// per-cycle output comparison, plus literal expectations for directed cases.
module tb_spi_slave_fsm;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [ADDR_W+1:0] rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] tx_data;
  logic              tx_valid;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [9:0] last_rx = '0;
  logic cmp_en = 1'b0;

  spi_slave_fsm #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: p counts consecutive low-SS_n edges. Edge 1 leaves idle,
  // edges 2..11 carry frame bits 9..0, edge 12 delivers the word.
  int         m_p;
  logic [9:0] m_fr;
  logic       m_rd_done;
  logic       m_rmode;
  logic [9:0] m_rxd;
  logic       m_rxv;
  logic       m_miso;
  int         m_tx_k;
  logic [7:0] m_tx_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p = 0; m_fr = '0; m_rd_done = 1'b0; m_rmode = 1'b0;
      m_rxd = '0; m_rxv = 1'b0; m_miso = 1'b0; m_tx_k = -1; m_tx_word = '0;
    end else begin
      m_rxv = 1'b0;
      if (SS_n) begin
        m_p = 0; m_fr = '0; m_miso = 1'b0; m_tx_k = -1;
      end else begin
        m_p++;
        if (m_p == 2) m_rmode = MOSI && m_rd_done;
        if (m_p >= 2 && m_p <= 11) m_fr = {m_fr[8:0], MOSI};
        if (m_p == 12) begin
          m_rxd = m_fr;
          m_rxv = 1'b1;
          if (m_fr[9:8] == 2'b10) m_rd_done = 1'b1;
          else if (m_fr[9:8] == 2'b11) m_rd_done = 1'b0;
        end
        if (m_p >= 13 && m_rmode) begin
          if (m_tx_k < 0) begin
            if (tx_valid) begin
              m_tx_word = tx_data;
              m_tx_k = 0;
            end
          end else begin
            m_tx_k++;
          end
        end
        m_miso = (m_tx_k >= 0 && m_tx_k < 8) ? m_tx_word[7 - m_tx_k] : 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("miso", 32'(MISO), 32'(m_miso));
      check("rx_valid", 32'(rx_valid), 32'(m_rxv));
      check("rx_data", 32'(rx_data), 32'(m_rxd));
      if (rx_valid) begin
        pulses++;
        last_rx = rx_data;
      end
    end
  end

  task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] f, input logic txv);
    tick(1'b0, 1'b0, txv, 8'hFF);
    for (int i = 9; i >= 0; i--) tick(1'b0, f[i], txv, 8'hFF);
    tick(1'b0, 1'b0, txv, 8'hFF);
  endtask

  initial begin
    int base;
    logic [7:0] exp_bits;
    logic [9:0] f;

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    cmp_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Write frame
    base = pulses;
    send_frame(10'h05A, 1'b0);
    check("wr_pulse", 32'(pulses - base), 32'd1);
    check("wr_rx_data", 32'(last_rx), 32'h05A);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    check("wr_miso", 32'(MISO), 32'd0);

    // Read address then read data
    send_frame(10'h25A, 1'b0);
    check("rdadd_rx_data", 32'(last_rx), 32'h25A);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h300, 1'b0);
    check("rddat_rx_data", 32'(last_rx), 32'h300);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check("rd_wait_miso", 32'(MISO), 32'd0);
    exp_bits = 8'hC3;
    tick(1'b0, 1'b0, 1'b1, 8'hC3);
    check("rd_bit7", 32'(MISO), 32'(exp_bits[7]));
    for (int i = 6; i >= 0; i--) begin
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      check("rd_bit", 32'(MISO), 32'(exp_bits[i]));
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check("rd_after_last", 32'(MISO), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // rd_addr_done was cleared: a 1-prefixed frame must land in READ_ADD
    send_frame(10'h2AA, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'hC3);
    tick(1'b0, 1'b0, 1'b1, 8'hC3);
    check("rdadd_ignores_tx", 32'(MISO), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Abort a write frame after 5 bits
    base = pulses;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    check("abort_no_pulse", 32'(pulses - base), 32'd0);
    send_frame(10'h1FF, 1'b0);
    check("post_abort_rx", 32'(last_rx), 32'h1FF);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Async reset mid-serialisation (rd_addr_done is 1 here)
    send_frame(10'h3C0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'hA5);
    check("pre_rst_miso", 32'(MISO), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check("pre_rst_miso2", 32'(MISO), 32'd1);
    #2;
    rst_n = 1'b0; SS_n = 1'b1;
    #1;
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h2C3, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'hA5);
    tick(1'b0, 1'b0, 1'b1, 8'hA5);
    check("post_rst_readadd", 32'(MISO), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Stray tx_valid in IDLE and WRITE
    tick(1'b1, 1'b0, 1'b1, 8'hFF);
    tick(1'b1, 1'b0, 1'b1, 8'hFF);
    check("stray_idle", 32'(MISO), 32'd0);
    send_frame(10'h0F0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'hFF);
    check("stray_write", 32'(MISO), 32'd0);
    check("stray_write_rx", 32'(last_rx), 32'h0F0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Back-to-back frames, one idle cycle between
    base = pulses;
    for (int c = 0; c < 4; c++) begin
      f = {2'(c), 8'(8'h10 + c)};
      send_frame(f, 1'b0);
      check("b2b_cmd", 32'(last_rx[9:8]), 32'(c));
      tick(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("b2b_pulses", 32'(pulses - base), 32'd4);

    tick(1'b1, 1'b0, 1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- SPI slave front end that deserialises MOSI frames into command+address/data words for the single-port RAM.
- Serialises RAM read data back onto MISO.
- Sits directly upstream of the RAM: drives its rx_valid/din inputs and consumes its tx_valid/dout outputs.
- Clocked by the SPI serial clock; one bit is transferred per rising edge.

Parameters:
- ADDR_W, 8: RAM address/data width. Frame width is ADDR_W+2 (2 command bits + payload).

Ports:
- clk  in  1  SPI clock; all sampling on rising edge
- rst_n  in  1  reset
- SS_n  in  1  slave select, active-low; frame boundary
- MOSI  in  1  serial in, MSB first
- MISO  out  1  serial out, MSB first
- rx_data  out  ADDR_W+2  assembled frame {cmd[1:0], payload} to RAM din
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  ADDR_W  RAM read data (dout)
- tx_valid  in  1  RAM read data valid

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.
- Clock and reset ports are named clk and rst_n.

Behaviour:
- Reset values: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_done=0, tx shift register=0.
- States are IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: stay while SS_n=1. SS_n=0 -> CHK_CMD.
- CHK_CMD: MOSI sampled here is frame bit 9 and is shifted in. Transitions:
  - SS_n=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - MOSI=1 and rd_addr_done=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA shift phase: bits 8..0 are shifted in on the next 9 edges (10 bits total, counter 0..9).
- rx_data is loaded and rx_valid=1 for exactly one cycle, on the edge after bit 0 is sampled. rx_valid=0 otherwise.
- rx_data holds its value until the next completed frame.
- rd_addr_done is updated on frame completion: cmd=2'b10 sets it, cmd=2'b11 clears it, cmd=2'b00/2'b01 leave it unchanged.
- WRITE / READ_ADD: after the frame completes, hold the state with no further capture until SS_n=1 -> IDLE.
- READ_DATA: after the frame completes, wait for tx_valid.
  - On the edge where tx_valid=1: load tx_data into the shift register and drive MISO <= tx_data[ADDR_W-1].
  - Each subsequent edge shifts out the next bit: ADDR_W bits in ADDR_W cycles, MSB first.
  - After the last bit, MISO=0. Stay in READ_DATA until SS_n=1.
- tx_valid is ignored in every state except READ_DATA-after-frame, and ignored once serialisation has started.
- SS_n=1 in any non-IDLE state -> IDLE on that edge. This aborts the frame:
  - no rx_valid;
  - counter cleared;
  - MISO=0;
  - rd_addr_done unchanged.
- Async reset mid-frame or mid-serialisation: all registers return to reset values immediately.
- Wrap-around: rd_addr_done persists across frames. Two consecutive READ_ADD frames simply re-set it.

Test Plan:
- Write frame: SS_n=0, MOSI 0_0_0x5A (10 bits), SS_n=1 -> rx_valid one cycle with rx_data=10'h05A; state back to IDLE; MISO stays 0.
- Read sequence:
  - Frame 10_0x5A -> rx_data=10'h25A, rd_addr_done=1.
  - Next frame 11_0x00 enters READ_DATA -> rx_data=10'h300.
  - Bench returns tx_valid with tx_data=8'hC3 -> MISO emits 1,1,0,0,0,0,1,1 on the following 8 edges, then 0; rd_addr_done=0.
- Abort: SS_n raised after 5 bits of a write frame -> no rx_valid; next full frame 01_0xFF -> rx_data=10'h1FF.
- Async reset asserted mid-MISO serialisation -> MISO=0, rx_valid=0, state IDLE immediately; next 1-prefixed frame goes to READ_ADD.
- Stray tx_valid=1 in IDLE and WRITE -> MISO remains 0, no state change.
- Back-to-back: frames 00, 01, 10, 11 each with SS_n high for 1 cycle between -> exactly four single-cycle rx_valid pulses with correct rx_data[9:8].
